// File: rtl/scope_trace_renderer_if.sv
// rtl/scope_trace_renderer_if.sv - ADC sample stream into the scope trace renderer
interface scope_trace_renderer_if;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/scope_trace_renderer.sv
// rtl/scope_trace_renderer.sv - triggered ADC capture into a double-buffered line and scope pixel colouring
module scope_trace_renderer #(
  parameter int H_SIZE    = 640,
  parameter int V_SIZE    = 480,
  parameter int V_OFFSET  = 112,
  parameter int GRID_X    = 64,
  parameter int GRID_Y    = 60,
  parameter int AUTO_TRIG = 4096
) (
  input  logic                  clock,
  input  logic                  reset_n,
  scope_trace_renderer_if.slave smp,
  input  logic [7:0]            trig_level,
  input  logic                  frame_start,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic                  pix_active,
  output logic [7:0]            colour_R,
  output logic [7:0]            colour_G,
  output logic [7:0]            colour_B,
  output logic                  capture_done
);
  localparam int AW = $clog2(AUTO_TRIG);

  typedef enum logic [1:0] {ARMED, CAPTURE, FULL} state_t;

  state_t        state;
  logic [9:0]    wr_addr;
  logic [AW-1:0] auto_cnt;
  logic [7:0]    prev_sample;
  logic          disp_bank;
  logic          disp_valid;

  logic          accept;
  logic          trig_hit;
  logic          auto_hit;
  logic          wr_en;
  logic [9:0]    wr_idx;

  logic [7:0]    bank0 [H_SIZE];
  logic [7:0]    bank1 [H_SIZE];

  logic          x_ok;
  logic [9:0]    rd_addr;
  logic [7:0]    rd_data;
  logic [9:0]    s1_x;
  logic [9:0]    s1_y;
  logic          s1_act;
  logic [9:0]    prev_row;
  logic [9:0]    row;
  logic [9:0]    prev_eff;
  logic [9:0]    row_lo;
  logic [9:0]    row_hi;
  logic          trace_hit;
  logic          grid_hit;

  assign smp.sample_ready = (state != FULL);
  assign capture_done     = (state == FULL);
  assign accept           = smp.sample_valid && smp.sample_ready;
  assign trig_hit         = (prev_sample < trig_level) && (smp.sample_data >= trig_level);
  assign auto_hit         = (auto_cnt == AW'(AUTO_TRIG - 1));

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = wr_addr;
    if (accept) begin
      if (state == ARMED) begin
        wr_en  = trig_hit || auto_hit;
        wr_idx = '0;
      end else if (state == CAPTURE) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARMED;
      wr_addr     <= '0;
      auto_cnt    <= '0;
      prev_sample <= '0;
      disp_bank   <= 1'b0;
      disp_valid  <= 1'b0;
    end else begin
      if (accept) prev_sample <= smp.sample_data;
      case (state)
        ARMED: begin
          if (accept) begin
            if (trig_hit || auto_hit) begin
              state   <= CAPTURE;
              wr_addr <= 10'd1;
            end else begin
              auto_cnt <= auto_cnt + AW'(1);
            end
          end
        end
        CAPTURE: begin
          if (accept) begin
            wr_addr <= wr_addr + 10'd1;
            if (wr_addr == 10'(H_SIZE - 1)) state <= FULL;
          end
        end
        FULL: begin
          // Swap only in blanking so a displayed frame never mixes two captures
          if (frame_start) begin
            disp_bank  <= ~disp_bank;
            disp_valid <= 1'b1;
            auto_cnt   <= '0;
            state      <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  assign x_ok    = (pix_x < 10'(H_SIZE));
  assign rd_addr = x_ok ? pix_x : '0;

  always_ff @(posedge clock) begin
    if (wr_en && disp_bank)  bank0[wr_idx] <= smp.sample_data;
    if (wr_en && !disp_bank) bank1[wr_idx] <= smp.sample_data;
    rd_data <= disp_bank ? bank1[rd_addr] : bank0[rd_addr];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_x   <= '0;
      s1_y   <= '0;
      s1_act <= 1'b0;
    end else begin
      s1_x   <= pix_x;
      s1_y   <= pix_y;
      s1_act <= pix_active && x_ok;
    end
  end

  // Spanning from the previous column's row joins steep edges into a solid line
  assign row       = 10'(V_OFFSET + 255) - {2'b00, rd_data};
  assign prev_eff  = (s1_x == '0) ? row : prev_row;
  assign row_lo    = (row < prev_eff) ? row : prev_eff;
  assign row_hi    = (row < prev_eff) ? prev_eff : row;
  assign trace_hit = disp_valid && (s1_y >= row_lo) && (s1_y <= row_hi);
  assign grid_hit  = ((32'(s1_x) % GRID_X) == 0) || ((32'(s1_y) % GRID_Y) == 0) ||
                     (s1_x == 10'(H_SIZE - 1)) || (s1_y == 10'(V_SIZE - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_row <= '0;
      colour_R <= '0;
      colour_G <= '0;
      colour_B <= '0;
    end else begin
      if (s1_act) prev_row <= row;
      if (!s1_act) begin
        colour_R <= 8'd0;
        colour_G <= 8'd0;
        colour_B <= 8'd0;
      end else if (trace_hit) begin
        colour_R <= 8'd0;
        colour_G <= 8'd255;
        colour_B <= 8'd0;
      end else if (grid_hit) begin
        colour_R <= 8'd64;
        colour_G <= 8'd64;
        colour_B <= 8'd64;
      end else begin
        colour_R <= 8'd0;
        colour_G <= 8'd0;
        colour_B <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_scope_trace_renderer.sv
// tb/tb_scope_trace_renderer.sv - random and directed checks of the scope renderer against a behavioural model
module tb_scope_trace_renderer;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] trig_level = 8'd128;
  logic       frame_start = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       pix_active = 1'b0;
  logic [7:0] colour_R, colour_G, colour_B;
  logic       capture_done;

  int checks = 0;
  int failures = 0;

  localparam int GREEN = 32'h00ff00;
  localparam int GREY  = 32'h404040;

  scope_trace_renderer_if smp();

  scope_trace_renderer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .smp         (smp),
    .trig_level  (trig_level),
    .frame_start (frame_start),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_active  (pix_active),
    .colour_R    (colour_R),
    .colour_G    (colour_G),
    .colour_B    (colour_B),
    .capture_done(capture_done)
  );

  always #5 clock = ~clock;

  // model: 0 waiting for trigger, 1 filling, 2 full
  int m_state, m_addr, m_auto, m_prev, m_db, m_last_row;
  bit m_dv;
  int m_buf [2][640];
  bit p_act, p_trace, p_grid;
  int exp_rgb;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_addr = 0; m_auto = 0; m_prev = 0; m_db = 0; m_dv = 0;
      m_last_row = 0; p_act = 0; p_trace = 0; p_grid = 0; exp_rgb = 0;
    end else begin
      int x, y, row, prv, d;
      if (!p_act) exp_rgb = 0;
      else if (p_trace && m_dv) exp_rgb = GREEN;
      else if (p_grid) exp_rgb = GREY;
      else exp_rgb = 0;
      x = int'(pix_x);
      y = int'(pix_y);
      p_act = pix_active && (x < 640);
      row = 367 - m_buf[m_db][(x < 640) ? x : 0];
      prv = (x == 0) ? row : m_last_row;
      p_trace = (y >= ((row < prv) ? row : prv)) && (y <= ((row < prv) ? prv : row));
      p_grid = (x % 64 == 0) || (y % 60 == 0) || (x == 639) || (y == 479);
      if (p_act) m_last_row = row;
      if (m_state == 2) begin
        if (frame_start) begin
          m_db = 1 - m_db; m_dv = 1; m_auto = 0; m_state = 0;
        end
      end else if (smp.sample_valid) begin
        d = int'(smp.sample_data);
        if (m_state == 0) begin
          if ((m_prev < int'(trig_level) && d >= int'(trig_level)) || m_auto == 4095) begin
            m_buf[1 - m_db][0] = d; m_addr = 1; m_state = 1;
          end else begin
            m_auto++;
          end
        end else begin
          m_buf[1 - m_db][m_addr] = d;
          if (m_addr == 639) m_state = 2;
          m_addr++;
        end
        m_prev = d;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  always @(posedge clock) begin
    #1;
    chk("model_rgb", int'({colour_R, colour_G, colour_B}), exp_rgb);
    chk("model_ready", int'(smp.sample_ready), int'(m_state != 2));
    chk("model_done", int'(capture_done), int'(m_state == 2));
  end

  function automatic logic [7:0] sample_of(input int kind, input int n);
    if (kind == 0) return 8'(n % 256);
    if (kind == 1) return 8'd50;
    return (n % 2 == 1) ? 8'd255 : 8'd0;
  endfunction

  task automatic feed_full(input int kind, input bit fs_on_last);
    int n = 0;
    forever begin
      @(negedge clock);
      if (m_state == 2 || n >= 20000) break;
      smp.sample_valid = 1'b1;
      smp.sample_data = sample_of(kind, n);
      frame_start = fs_on_last && (m_state == 1) && (m_addr == 639);
      n++;
    end
    smp.sample_valid = 1'b0;
    frame_start = 1'b0;
    if (m_state != 2) bound_fail("feed_full");
  endtask

  task automatic pulse_fs();
    @(negedge clock) frame_start = 1'b1;
    @(negedge clock) frame_start = 1'b0;
  endtask

  task automatic show(input int x, input int y);
    @(negedge clock);
    pix_x = 10'(x); pix_y = 10'(y); pix_active = 1'b1;
  endtask

  task automatic expect_pix(input string name, input int rgb);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk(name, int'({colour_R, colour_G, colour_B}), rgb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    smp.sample_valid = 1'b0;
    smp.sample_data = 8'd0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_rgb", int'({colour_R, colour_G, colour_B}), 0);
    chk("reset_ready", int'(smp.sample_ready), 1);
    chk("reset_done", int'(capture_done), 0);

    show(0, 0);   expect_pix("grid_00", GREY);
    show(5, 7);   expect_pix("black_57", 0);
    show(12, 367); expect_pix("no_trace_before_swap", 0);

    trig_level = 8'd128;
    feed_full(0, 1'b0);
    chk("full_ready", int'(smp.sample_ready), 0);
    chk("full_done", int'(capture_done), 1);
    pulse_fs();
    show(0, 239); expect_pix("ramp_x0", GREEN);
    show(0, 240); expect_pix("ramp_x0_grid", GREY);

    trig_level = 8'd200;
    feed_full(1, 1'b0);
    pulse_fs();
    show(10, 317); expect_pix("auto_317", GREEN);
    show(10, 316); expect_pix("auto_316", 0);

    trig_level = 8'd128;
    feed_full(2, 1'b0);
    pulse_fs();
    for (int y = 112; y <= 367; y++) begin
      show(0, y);
      show(1, y);
      expect_pix("join_col1", GREEN);
    end
    show(0, 111); show(1, 111); expect_pix("join_row111", 0);

    show(0, 0);
    trig_level = 8'd128;
    n = 0;
    forever begin
      @(negedge clock);
      if ((m_state == 1 && m_addr == 300) || n >= 2000) break;
      smp.sample_valid = 1'b1;
      smp.sample_data = sample_of(0, n);
      n++;
    end
    if (n >= 2000) bound_fail("reach_addr300");
    chk("pre_reset_rgb", int'({colour_R, colour_G, colour_B}), GREY);
    reset_n = 1'b0;
    #1;
    chk("async_rgb", int'({colour_R, colour_G, colour_B}), 0);
    chk("async_done", int'(capture_done), 0);
    chk("async_ready", int'(smp.sample_ready), 1);
    smp.sample_valid = 1'b0;
    pix_active = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    feed_full(0, 1'b1);
    show(0, 239); expect_pix("coincide_no_swap", GREY);
    pulse_fs();
    show(0, 239); expect_pix("coincide_next_swap", GREEN);

    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      smp.sample_valid = ($urandom_range(1, 0) == 1);
      smp.sample_data = 8'($urandom_range(255, 0));
      if ($urandom_range(15, 0) == 0) trig_level = 8'($urandom_range(255, 0));
      frame_start = ($urandom_range(199, 0) == 0);
      pix_x = 10'($urandom_range(699, 0));
      pix_y = 10'($urandom_range(479, 0));
      pix_active = ($urandom_range(9, 0) != 0);
    end
    @(negedge clock);
    smp.sample_valid = 1'b0;
    frame_start = 1'b0;
    pix_active = 1'b0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scope_trace_renderer.md
Name: scope_trace_renderer

Overview:
- Pixel-colour source that sits directly upstream of the VGA timing/pixel-drive stage; its colour_R/G/B outputs connect to that stage's colour inputs.
- Captures triggered ADC samples into a double-buffered 640-entry line buffer.
- For each pixel coordinate it is given, returns trace, graticule or background colour.
- Capture runs into one bank while the other bank is displayed; the banks swap only at frame boundaries, so no tearing occurs.

Parameters:
- H_SIZE, 640, samples per capture and visible columns.
- V_SIZE, 480, visible rows.
- V_OFFSET, 112, screen row of sample value 255; value s maps to row V_OFFSET+(255-s).
- GRID_X, 64, vertical graticule pitch in columns.
- GRID_Y, 60, horizontal graticule pitch in rows.
- AUTO_TRIG, 4096, samples accepted in ARMED with no trigger before a forced capture start.

Ports:
- clock  in  1  pixel/system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_data  in  8  unsigned ADC sample.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_ready  out  1  block accepts a sample this cycle; transfer occurs when valid && ready.
- trig_level  in  8  rising-edge trigger threshold.
- frame_start  in  1  one-cycle pulse from the timing stage at start of vertical blank.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- pix_active  in  1  pix_x/pix_y lie in the visible region.
- colour_R  out  8  red, pipelined.
- colour_G  out  8  green, pipelined.
- colour_B  out  8  blue, pipelined.
- capture_done  out  1  high while state is FULL.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State ARMED; write address 0; auto counter 0; prev_sample 0.
  - disp_bank 0; disp_valid 0.
  - colour outputs 0; capture_done 0; sample_ready 1 after reset deasserts.
  - Line-buffer contents are not reset.
- Capture FSM, per accepted sample:
  - ARMED:
    - Trigger fires when prev_sample < trig_level and sample_data >= trig_level.
    - On trigger, or when the auto counter reaches AUTO_TRIG-1, write the sample to capture bank address 0 and go to CAPTURE with address 1.
    - Otherwise discard the sample and increment the auto counter.
    - prev_sample updates on every accepted sample.
  - CAPTURE:
    - Write each sample to capture bank[address] and increment the address.
    - The write to address H_SIZE-1 moves the FSM to FULL.
  - FULL:
    - sample_ready is 0 and no writes occur.
    - On frame_start: flip disp_bank, set disp_valid to 1, clear the auto counter, go to ARMED.
- Capture bank is always !disp_bank.
- frame_start in ARMED or CAPTURE is ignored; the displayed bank is unchanged.
- frame_start in the same cycle as the final write is ignored, because the state is not yet FULL. The swap happens at the next frame_start.
- sample_ready = (state != FULL), combinational from state.
- Render pipeline, fixed latency of 2 clocks from pix_x/pix_y/pix_active to colour:
  - Stage 1: synchronous read of disp_bank[pix_x]; register pix_x, pix_y and pix_active.
  - Stage 2: compute row = V_OFFSET+255-data.
  - prev_row holds the row of the previous column. It is forced equal to row when the stage-1 x is 0, and updates only when stage-1 pix_active is 1.
  - Trace hit when disp_valid and pix_y is in [min(row,prev_row), max(row,prev_row)]. This joins consecutive samples vertically.
  - Grid hit when x%GRID_X==0, y%GRID_Y==0, x==H_SIZE-1, or y==V_SIZE-1.
  - Colour priority: inactive gives (0,0,0); trace gives (0,255,0); grid gives (64,64,64); otherwise (0,0,0). The result is registered.
- Arithmetic: row is 10-bit unsigned. pix_x is used as a buffer address only when < H_SIZE; out-of-range x reads address 0 and is forced inactive.
- Reset mid-capture: partial data is abandoned; disp_valid returns to 0, so no trace is drawn until the next full capture swaps in.

Test Plan:
- Reset, then drive any pixels with pix_active=1 → trace never drawn. Pixel (0,0) gives (64,64,64) 2 cycles later; pixel (5,7) gives (0,0,0).
- trig_level=128, feed ramp 0..255 repeating, then pulse frame_start → capture starts at sample 128. Pixel (0, 112+255-128=239) gives (0,255,0); sample_ready is 0 while FULL.
- Constant samples 50 with trig_level=200 → after 4096 samples an auto capture fills the buffer. Column 10 draws only row 317 green.
- Alternating samples 0/255 per column, scan column 1 rows 112..367 → all rows green (vertical join); row 111 is black or grid.
- frame_start coincides with the final (640th) write → no swap and disp_valid stays 0. The next frame_start swaps the banks.
- Assert reset_n low mid-CAPTURE at address 300 → state ARMED, capture_done 0, all outputs 0 immediately (asynchronous).
